// File: rtl/alu_issue_sequencer.sv
// alu_issue_sequencer: 4-cycle issue/writeback sequencer around an external ALU with a local 16x32 regfile.
// Define RETIRE_CNT_EN to add the retire_count output (count of completed instructions).
module alu_issue_sequencer #(
    parameter int NREGS = 16,
    parameter int IMM_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic [3:0]  ALU_opcode,
    input  logic [31:0] ALU_out,
    input  logic        ALU_zero,
    output logic        done_valid,
    output logic [3:0]  done_rd,
    output logic [31:0] done_data,
    output logic        branch_taken,
    output logic [31:0] branch_offset,
    output logic        illegal,
    input  logic [3:0]  dbg_addr,
`ifdef RETIRE_CNT_EN
    output logic [31:0] retire_count,
`endif
    output logic [31:0] dbg_data
);

    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_NAND  = 4'd2;
    localparam logic [3:0] OP_ADDI  = 4'd3;
    localparam logic [3:0] OP_BEQ   = 4'd4;
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_NAND = 4'b0010;

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    function automatic logic signed [31:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(32-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [3:0]  opc_q, opc_d;
    logic [31:0] res_q, res_d;
    logic        zero_q, zero_d;
    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];
    logic        done_valid_q, done_valid_d;
    logic [3:0]  done_rd_q, done_rd_d;
    logic [31:0] done_data_q, done_data_d;
    logic        branch_taken_q, branch_taken_d;
    logic [31:0] branch_offset_q, branch_offset_d;
    logic        illegal_q, illegal_d;

    logic [3:0]        op, rd, rs1, rs2;
    logic signed [31:0] imm_ext;
    logic [31:0]       rs1_val, rs2_val;
    logic              is_legal, is_beq, writes_rd;
    logic [3:0]        alu_sel;

    assign op        = instr_q[31:28];
    assign rd        = instr_q[27:24];
    assign rs1       = instr_q[23:20];
    assign rs2       = instr_q[19:16];
    assign imm_ext   = sext_imm(instr_q[IMM_W-1:0]);
    assign rs1_val   = (rs1 == 4'd0) ? 32'd0 : regs_q[rs1];
    assign rs2_val   = (rs2 == 4'd0) ? 32'd0 : regs_q[rs2];
    assign is_legal  = (op <= OP_BEQ);
    assign is_beq    = (op == OP_BEQ);
    assign writes_rd = (op <= OP_ADDI);

    always_comb begin
        case (op)
            OP_SUB, OP_BEQ: alu_sel = ALU_SUB;
            OP_NAND:        alu_sel = ALU_NAND;
            default:        alu_sel = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        instr_d         = instr_q;
        a_d             = a_q;
        b_d             = b_q;
        opc_d           = opc_q;
        res_d           = res_q;
        zero_d          = zero_q;
        regs_d          = regs_q;
        done_valid_d    = 1'b0;
        done_rd_d       = done_rd_q;
        done_data_d     = done_data_q;
        branch_taken_d  = 1'b0;
        branch_offset_d = branch_offset_q;
        illegal_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                // Illegal opcodes leave the ALU inputs untouched and skip EXEC.
                if (is_legal) begin
                    a_d     = rs1_val;
                    b_d     = (op == OP_ADDI) ? imm_ext : rs2_val;
                    opc_d   = alu_sel;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_WB;
                end
            end
            S_EXEC: begin
                res_d   = ALU_out;
                zero_d  = ALU_zero;
                state_d = S_WB;
            end
            S_WB: begin
                done_valid_d    = 1'b1;
                done_rd_d       = rd;
                done_data_d     = res_q;
                branch_taken_d  = is_beq && zero_q;
                branch_offset_d = imm_ext;
                illegal_d       = !is_legal;
                if (writes_rd && (rd != 4'd0)) begin
                    regs_d[rd] = res_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            instr_q         <= '0;
            a_q             <= '0;
            b_q             <= '0;
            opc_q           <= ALU_ADD;
            res_q           <= '0;
            zero_q          <= 1'b0;
            done_valid_q    <= 1'b0;
            done_rd_q       <= '0;
            done_data_q     <= '0;
            branch_taken_q  <= 1'b0;
            branch_offset_q <= '0;
            illegal_q       <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q         <= state_d;
            instr_q         <= instr_d;
            a_q             <= a_d;
            b_q             <= b_d;
            opc_q           <= opc_d;
            res_q           <= res_d;
            zero_q          <= zero_d;
            done_valid_q    <= done_valid_d;
            done_rd_q       <= done_rd_d;
            done_data_q     <= done_data_d;
            branch_taken_q  <= branch_taken_d;
            branch_offset_q <= branch_offset_d;
            illegal_q       <= illegal_d;
            regs_q          <= regs_d;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [31:0] retire_q, retire_d;

    always_comb begin
        retire_d = retire_q + {31'd0, done_valid_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_q <= '0;
        end else begin
            retire_q <= retire_d;
        end
    end

    assign retire_count = retire_q;
`endif

    assign instr_ready   = (state_q == S_IDLE);
    assign A             = a_q;
    assign B             = b_q;
    assign ALU_opcode    = opc_q;
    assign done_valid    = done_valid_q;
    assign done_rd       = done_rd_q;
    assign done_data     = done_data_q;
    assign branch_taken  = branch_taken_q;
    assign branch_offset = branch_offset_q;
    assign illegal       = illegal_q;
    assign dbg_data      = (dbg_addr == 4'd0) ? 32'd0 : regs_q[dbg_addr];

endmodule
